bcd_to_bin_seq: RTL
===================

Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3). It is the inverse path of the team's binary-to-BCD display chain.
- Converts NDIG packed BCD digits (e.g. keypad or display-entry values) into an unsigned binary word.
- Performs one shift per clock and uses a start/busy/done handshake. The result is held until the next conversion completes.

Parameters:
- NDIG, 3, number of BCD digits; bcd_in is 4*NDIG bits, most significant digit in the top nibble.
- NBITS, 10, binary result width; must satisfy 2^NBITS > 10^NDIG - 1 (3 digits -> 10 bits).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*NDIG  packed BCD operand; captured on the start edge.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse; bin_out is valid from this cycle onward.
- bin_out  output  NBITS  binary result, held until the next done.
- err  output  1  invalid-digit flag; constant 0 unless BCD_DIGIT_CHECK_EN is defined.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, err = 0, bin_out = 0.
  - Internal shift register and counter cleared.
- Reset mid-conversion aborts immediately. The partial result is discarded and bin_out returns to 0.
- Internal working register is {bcd_sr[4*NDIG-1:0], bin_sr[NBITS-1:0]}, plus a counter cnt of width clog2(NBITS+1).
- IDLE:
  - On a clk edge with start=1: bcd_sr <= bcd_in, bin_sr <= 0, cnt <= 0, state -> SHIFT.
  - With start=0, hold.
- SHIFT, on each edge:
  - Step 1: logical right shift of the concatenated register by one. The LSB of bcd_sr enters the MSB of bin_sr; 0 enters the MSB of bcd_sr.
  - Step 2: if cnt < NBITS-1, every nibble of the shifted bcd_sr that is >= 8 has 3 subtracted (4-bit, no borrow across nibbles).
  - Step 3: cnt <= cnt + 1.
  - When cnt == NBITS-1 (the NBITS-th shift): bin_out <= final shifted bin_sr, state -> DONE.
- DONE:
  - done = 1 for exactly one cycle, then state -> IDLE.
  - start is ignored in DONE; it is not queued.
- busy = 1 exactly while state == SHIFT.
- Latency: start sampled at edge T0; shifts occur on edges T1..TNBITS; done is high between TNBITS and TNBITS+1. Default latency is 10 cycles.
- Throughput: one conversion per NBITS+2 cycles. start held high continuously re-triggers on each return to IDLE.
- start asserted during SHIFT or DONE is ignored. bcd_in changes after the start edge have no effect.
- bin_out changes only on the DONE transition (or reset); it is stable at all other times.
- Outputs are registered; no combinational path from any input to any output.
- Overflow is impossible given the parameter constraint. Result for valid BCD equals the decimal value (0..10^NDIG - 1).

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - At the start edge, any nibble of bcd_in > 9 causes state -> DONE directly with no SHIFT cycles (busy stays 0).
  - err <= 1 and bin_out <= 0, so done pulses on the cycle after start.
  - err holds until the next accepted start, which clears it; a valid conversion finishes with err = 0.
- Not defined:
  - err is tied to 0 and no digit check is made.
  - Invalid nibbles go through the normal algorithm; the result is deterministic but unspecified.

Test Plan:
- Reset mid-run:
  - Assert rst_n=0 during SHIFT: busy, done, bin_out and err go to 0 asynchronously, with no done pulse.
  - After release, start with bcd_in=0x042 -> bin_out=42 (0x02A).
- Basic conversions:
  - start with bcd_in=0x999 -> done exactly 10 cycles after the start edge, bin_out=999 (0x3E7), busy high for 10 cycles.
  - bcd_in=0x000 -> bin_out=0.
  - bcd_in=0x012 -> bin_out=12.
  - bcd_in=0x255 -> bin_out=255.
  - bcd_in=0x100 -> bin_out=100.
- Back-to-back:
  - Hold start=1 with bcd_in=0x123, then change it to 0x456 during SHIFT.
  - First result = 123; the second conversion starts after DONE->IDLE and yields 456.
  - done pulses exactly once per conversion.
- Ignored start:
  - Pulse start during SHIFT with a different bcd_in: the current result is unaffected, with no extra done.
  - bin_out holds its previous value until the new done.
- Invalid digit (BCD_DIGIT_CHECK_EN defined):
  - bcd_in=0x1A3 -> done on the next cycle, err=1, bin_out=0, busy never high.
  - A following start with 0x007 -> err=0, bin_out=7.
- Random sweep: all 1000 valid 3-digit codes compared against the decimal reference model, checking value and 10-cycle latency.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one shift per clock).
// Optional invalid-digit rejection enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin_seq #(
  parameter int unsigned NDIG  = 3,
  parameter int unsigned NBITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [NBITS-1:0]  bin_out,
  output logic              err
);

  localparam int unsigned BCDW = 4 * NDIG;
  localparam int unsigned SRW  = BCDW + NBITS;
  localparam int unsigned CW   = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [BCDW-1:0]   r_bcd;
  logic [NBITS-1:0]  r_bin;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [NBITS-1:0]  r_bin_out;

  logic [SRW-1:0]    w_shift;
  logic [BCDW-1:0]   w_bcd_adj;
  logic              w_last;
  logic              w_reject;

  // One reverse double-dabble step: shift right, then correct nibbles >= 8 except after the last shift.
  always_comb begin
    w_shift   = {r_bcd, r_bin} >> 1;
    w_last    = (r_cnt == CW'(NBITS - 1));
    w_bcd_adj = w_shift[SRW-1 -: BCDW];
    if (!w_last) begin
      for (int d = 0; d < int'(NDIG); d++) begin
        if (w_bcd_adj[4*d+3]) begin
          w_bcd_adj[4*d +: 4] = w_bcd_adj[4*d +: 4] - 4'd3;
        end
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  // Any nibble above 9 rejects the operand at the start edge.
  always_comb begin
    w_reject = 1'b0;
    for (int d = 0; d < int'(NDIG); d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        w_reject = 1'b1;
      end
    end
  end
`else
  assign w_reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_bin_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err <= w_reject;
            if (w_reject) begin
              r_bin_out <= '0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_bcd   <= bcd_in;
              r_bin   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_adj;
          r_bin <= w_shift[NBITS-1:0];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_bin_out <= w_shift[NBITS-1:0];
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign bin_out = r_bin_out;

endmodule
